random_enemy: RTL and testbench



---
 rtl/random_enemy.sv | 65 ++++++
 tb/tb_random_enemy.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/random_enemy.sv
// Enemy lane selector: picks lane 0..2 on each trigger rising edge from a
// free-running Galois LFSR mixed with ammo and time; never three repeats in a row.
module random_enemy (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger,
  input  logic [7:0] ammo,
  input  logic [7:0] tm,
  output logic [1:0] rng
);

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;
  logic        trig_q;
  logic        req;
  logic [1:0]  last;
  logic        last_v;
  logic        rng_v;
  logic [7:0]  mix;
  logic [7:0]  mix_mod;
  logic [1:0]  lane_raw;
  logic [1:0]  lane;

  // An all-zero LFSR would lock up, so it is reseeded instead.
  always_comb begin
    lfsr_nxt = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    if (lfsr == 16'h0000) lfsr_nxt = LFSR_SEED;
  end

  assign req      = trigger & ~trig_q;
  assign mix      = lfsr[7:0] ^ ammo ^ {tm[3:0], tm[7:4]};
  assign mix_mod  = mix % 8'd3;
  assign lane_raw = mix_mod[1:0];

  always_comb begin
    lane = lane_raw;
    if (last_v && (lane_raw == rng) && (lane_raw == last))
      lane = (lane_raw == 2'd2) ? 2'd0 : lane_raw + 2'd1;
  end

  // last_v follows rng_v so the repeat rule only sees lanes issued since reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr   <= LFSR_SEED;
      trig_q <= 1'b0;
      rng    <= 2'd0;
      last   <= 2'd0;
      last_v <= 1'b0;
      rng_v  <= 1'b0;
    end else begin
      lfsr   <= lfsr_nxt;
      trig_q <= trigger;
      if (req) begin
        last   <= rng;
        last_v <= rng_v;
        rng_v  <= 1'b1;
        rng    <= lane;
      end
    end
  end

endmodule

// File: tb/tb_random_enemy.sv
// Self-checking bench for random_enemy: reference model feeds a scoreboard
// queue at request time; results are popped and compared after the edge.
module tb_random_enemy;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       trigger = 1'b0;
  logic [7:0] ammo = 8'd0;
  logic [7:0] tm = 8'd0;
  logic [1:0] rng;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_q[$];

  logic [15:0] m_lfsr;
  logic [1:0]  m_rng, m_last;
  logic        m_rngv, m_lastv;

  int p1, p2, n_since_rst;
  int lane_cnt[3];

  random_enemy dut (
    .clk(clk), .reset(reset), .trigger(trigger),
    .ammo(ammo), .tm(tm), .rng(rng)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) m_lfsr <= 16'hACE1;
    else if (m_lfsr == 16'h0000) m_lfsr <= 16'hACE1;
    else m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int lane_of(input logic [15:0] l, input logic [7:0] a, input logic [7:0] t);
    logic [7:0] m;
    int v;
    m = l[7:0] ^ a ^ {t[3:0], t[7:4]};
    v = m;
    return v % 3;
  endfunction

  // Advance the history model for one request and queue its expected lane.
  task automatic push_expected(input logic [7:0] a, input logic [7:0] t);
    int ln;
    ln = lane_of(m_lfsr, a, t);
    if (m_lastv && ln == m_rng && ln == m_last) ln = (ln + 1) % 3;
    m_last  = m_rng;
    m_lastv = m_rngv;
    m_rngv  = 1'b1;
    m_rng   = ln[1:0];
    exp_q.push_back(ln[1:0]);
  endtask

  task automatic pop_check(input string tag);
    logic [1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check(tag, rng, e);
    end
  endtask

  // Call at a negedge; ends at a negedge with reset released and trigger low.
  task automatic do_reset(input logic trig);
    reset = 1'b1;
    trigger = trig;
    @(posedge clk); #1;
    check("reset_rng", rng, 0);
    check("reset_last_v", dut.last_v, 0);
    m_rng = 0; m_last = 0; m_rngv = 0; m_lastv = 0;
    exp_q.delete();
    n_since_rst = 0;
    @(negedge clk);
    reset = 1'b0;
    trigger = 1'b0;
  endtask

  // Call at a negedge; drives one request, checks, then idles gap low cycles.
  task automatic request(input logic [7:0] a, input logic [7:0] t, input int gap, input string tag);
    ammo = a; tm = t; trigger = 1'b1;
    push_expected(a, t);
    @(posedge clk); #1;
    pop_check(tag);
    check({tag, "_range"}, (rng == 2'd3) ? 1 : 0, 0);
    n_since_rst++;
    if (n_since_rst >= 3) check({tag, "_no_triple"}, (rng == p1[1:0] && p1 == p2) ? 1 : 0, 0);
    p2 = p1; p1 = rng;
    @(negedge clk);
    trigger = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  function automatic logic [7:0] ammo_for_lane(input int want);
    for (int a = 0; a < 100; a++)
      if (lane_of(m_lfsr, a[7:0], 8'd0) == want) return a[7:0];
    return 8'd0;
  endfunction

  initial begin
    logic [1:0] held;
    logic [7:0] a;
    p1 = 0; p2 = 0; n_since_rst = 0;
    @(negedge clk);

    // Test plan value 1: ammo=tm=60 at first edge after reset -> lane 0
    do_reset(1'b0);
    request(8'd60, 8'd60, 1, "tp_mix30");
    check("tp_mix30_const", rng, 0);

    // Test plan value 2: ammo=1, tm=0 -> lane 2
    do_reset(1'b0);
    request(8'd1, 8'd0, 1, "tp_mix224");
    check("tp_mix224_const", rng, 2);

    // Held trigger: one update only; LFSR keeps stepping
    do_reset(1'b0);
    ammo = 8'd1; tm = 8'd0; trigger = 1'b1;
    push_expected(8'd1, 8'd0);
    @(posedge clk); #1;
    pop_check("hold_first");
    check("hold_lfsr_step", dut.lfsr, 16'hE270);
    held = rng;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      ammo = 8'(i * 7); tm = 8'(i * 11);
      @(posedge clk); #1;
      check("hold_stable", rng, held);
    end
    @(negedge clk);
    trigger = 1'b0;
    @(negedge clk);

    // Random stream
    do_reset(1'b0);
    lane_cnt[0] = 0; lane_cnt[1] = 0; lane_cnt[2] = 0;
    for (int i = 0; i < 200; i++) begin
      request(8'($urandom_range(0, 99)), 8'($urandom_range(0, 99)), $urandom_range(1, 3), "rand");
      if (rng != 2'd3) lane_cnt[rng]++;
    end
    check("lane0_min40", (lane_cnt[0] >= 40) ? 1 : 0, 1);
    check("lane1_min40", (lane_cnt[1] >= 40) ? 1 : 0, 1);
    check("lane2_min40", (lane_cnt[2] >= 40) ? 1 : 0, 1);

    // Reset coincident with a trigger rising edge mid-game
    request(8'd5, 8'd9, 2, "pre_rst");
    do_reset(1'b1);
    request(8'd1, 8'd0, 1, "post_rst");
    check("post_rst_const", rng, 2);

    // Forced anti-repeat: lanes 1,1 then a computed 1 becomes 2
    do_reset(1'b0);
    for (int k = 0; k < 3; k++) begin
      a = ammo_for_lane(1);
      check("anti_setup_lane1", lane_of(m_lfsr, a, 8'd0), 1);
      request(a, 8'd0, 2, "anti");
      check("anti_const", rng, (k < 2) ? 1 : 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
